// File: rtl/duft_pkg.sv
// Shared definitions for the DUFT access path: FSM state encoding, the
// idle address value, the DUFT register map and the opcode values.
package duft_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_IDLE = 3'd1,
    S_START     = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_RESP      = 3'd4
  } duft_state_t;

  // Address presented to the DUFT whenever no access is in flight.
  localparam logic [31:0] DUFT_INVALID_ADDR = 32'hFFFF_FFFF;

  // Read data returned with an aborted (timed-out) access.
  localparam logic [31:0] DUFT_ABORT_RDATA  = 32'hFFFF_FFFF;

  // DUFT register map.
  localparam logic [31:0] DUFT_ADDR_OPCODE   = 32'h0000_0000;
  localparam logic [31:0] DUFT_ADDR_STATE    = 32'h0000_0001;
  localparam logic [31:0] DUFT_ADDR_CONFIG   = 32'h0000_0002;
  localparam logic [31:0] DUFT_ADDR_DUT_IN   = 32'h0000_0010;
  localparam logic [31:0] DUFT_ADDR_DUT_OUT  = 32'h0000_0018;
  localparam logic [31:0] DUFT_ADDR_DFT_OUT  = 32'h0000_0020;
  localparam logic [31:0] DUFT_ADDR_TEST_IN  = 32'hFF00_0000;
  localparam logic [31:0] DUFT_ADDR_TEST_OUT = 32'hFF00_0001;

  // Opcodes written to the OPCODE register.
  localparam logic [31:0] DUFT_OP_INPUT = 32'h0000_0001;
  localparam logic [31:0] DUFT_OP_RUN   = 32'h0000_0002;
  localparam logic [31:0] DUFT_OP_ENDR  = 32'h0000_0003;

  // States in which the master is waiting on the DUFT and the timer runs.
  function automatic logic is_wait_state(input duft_state_t s);
    return (s == S_WAIT_IDLE) || (s == S_WAIT_DONE);
  endfunction

endpackage

// File: rtl/duft_wait_timer.sv
// Wait-state watchdog: counts cycles spent in the current state and flags
// the cycle that would exceed TIMEOUT cycles of waiting.
module duft_wait_timer #(
  parameter int TIMEOUT = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);

  logic [15:0] count;

  // Cycle counter: restarts on every state entry, saturates instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && (count != 16'hFFFF)) begin
      count <= count + 16'd1;
    end
  end

  // The count equals the number of cycles already spent in this state, so
  // LIMIT marks the last permitted waiting cycle.
  assign expired = enable && (count == LIMIT);

endmodule

// File: rtl/duft_ap_master.sv
// Command/response master that sequences one DUFT access at a time over
// an ap_ctrl_chain handshake, with a watchdog on every wait state.
module duft_ap_master
  import duft_pkg::*;
#(
  parameter int          TIMEOUT      = 200,
  parameter logic [31:0] INVALID_ADDR = DUFT_INVALID_ADDR
) (
  input  logic        clk,
  input  logic        ap_rst,
  // upstream command channel
  input  logic        cmd_val,
  output logic        cmd_rdy,
  input  logic        cmd_rd_wr,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  // upstream response channel
  output logic        rsp_val,
  input  logic        rsp_rdy,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  // DUFT side
  output logic [31:0] addr,
  output logic [31:0] wr_data,
  output logic        rd_wr,
  output logic        ap_start,
  output logic        ap_continue,
  output logic        ap_ce,
  input  logic        ap_idle,
  input  logic        ap_ready,
  input  logic        ap_done,
  input  logic [31:0] ap_return,
  input  logic        ce_en
);

  duft_state_t state_q;
  duft_state_t state_nxt;

  logic timer_clear;
  logic timer_en;
  logic timer_expired;

  // ap_ready carries no sequencing meaning here; completion is taken from ap_done.
  logic ap_ready_unused;
  assign ap_ready_unused = ap_ready;

  assign timer_clear = (state_nxt != state_q);
  assign timer_en    = is_wait_state(state_q);

  duft_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (ap_rst),
    .clear   (timer_clear),
    .enable  (timer_en),
    .expired (timer_expired)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (ap_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next-state decode; a live ap_idle/ap_done wins over a simultaneous timeout.
  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_val) state_nxt = S_WAIT_IDLE;
      end
      S_WAIT_IDLE: begin
        if (ap_idle)            state_nxt = S_START;
        else if (timer_expired) state_nxt = S_RESP;
      end
      S_START: begin
        state_nxt = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (ap_done)            state_nxt = S_RESP;
        else if (timer_expired) state_nxt = S_RESP;
      end
      S_RESP: begin
        if (rsp_rdy) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // State-decoded handshake outputs; cmd_rdy depends only on state and reset.
  always_comb begin
    cmd_rdy  = (state_q == S_IDLE) && !ap_rst;
    rsp_val  = (state_q == S_RESP);
    ap_start = (state_q == S_START) || (state_q == S_WAIT_DONE);
  end

  // Access registers: command capture, result capture and the continue pulse.
  always_ff @(posedge clk) begin
    if (ap_rst) begin
      addr        <= INVALID_ADDR;
      wr_data     <= '0;
      rd_wr       <= 1'b1;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      ap_continue <= 1'b0;
    end else begin
      ap_continue <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_val) begin
            addr    <= cmd_addr;
            rd_wr   <= cmd_rd_wr;
            wr_data <= cmd_wdata;
          end
        end
        S_WAIT_IDLE: begin
          if (!ap_idle && timer_expired) begin
            rsp_err   <= 1'b1;
            rsp_rdata <= DUFT_ABORT_RDATA;
          end
        end
        S_WAIT_DONE: begin
          if (ap_done) begin
            rsp_err     <= 1'b0;
            rsp_rdata   <= rd_wr ? ap_return : 32'h0;
            ap_continue <= 1'b1;
          end else if (timer_expired) begin
            rsp_err   <= 1'b1;
            rsp_rdata <= DUFT_ABORT_RDATA;
          end
        end
        S_RESP: begin
          if (rsp_rdy) begin
            addr  <= INVALID_ADDR;
            rd_wr <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Clock-enable follows ce_en one cycle later, regardless of FSM state.
  always_ff @(posedge clk) begin
    if (ap_rst) begin
      ap_ce <= 1'b0;
    end else begin
      ap_ce <= ce_en;
    end
  end

endmodule

// File: tb/tb_duft_ap_master.sv
// Directed bench for duft_ap_master with a behavioural DUFT responder.
module tb_duft_ap_master;
  import duft_pkg::*;

  logic        clk = 1'b0;
  logic        ap_rst = 1'b1;
  logic        cmd_val = 1'b0;
  logic        cmd_rdy;
  logic        cmd_rd_wr = 1'b1;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_val;
  logic        rsp_rdy = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] addr;
  logic [31:0] wr_data;
  logic        rd_wr;
  logic        ap_start;
  logic        ap_continue;
  logic        ap_ce;
  logic        ap_idle = 1'b1;
  logic        ap_ready = 1'b0;
  logic        ap_done = 1'b0;
  logic [31:0] ap_return = '0;
  logic        ce_en = 1'b1;

  duft_ap_master dut (
    .clk         (clk),
    .ap_rst      (ap_rst),
    .cmd_val     (cmd_val),
    .cmd_rdy     (cmd_rdy),
    .cmd_rd_wr   (cmd_rd_wr),
    .cmd_addr    (cmd_addr),
    .cmd_wdata   (cmd_wdata),
    .rsp_val     (rsp_val),
    .rsp_rdy     (rsp_rdy),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err),
    .addr        (addr),
    .wr_data     (wr_data),
    .rd_wr       (rd_wr),
    .ap_start    (ap_start),
    .ap_continue (ap_continue),
    .ap_ce       (ap_ce),
    .ap_idle     (ap_idle),
    .ap_ready    (ap_ready),
    .ap_done     (ap_done),
    .ap_return   (ap_return),
    .ce_en       (ce_en)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Monitors
  int cyc = 0;
  int cont_cnt = 0;
  int start_rises = 0;
  int rsp_val_cycles = 0;
  logic start_prev = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (ap_continue) cont_cnt++;
    if (rsp_val) rsp_val_cycles++;
    if (ap_start && !start_prev) start_rises++;
    start_prev = ap_start;
  end

  // Responder model (driven on the falling edge)
  logic        idle_block = 1'b0;
  logic        force_done = 1'b0;
  int          done_lat   = 0;
  int          start_cnt  = 0;
  logic [31:0] test_reg = '0;
  logic [31:0] dut_in_reg = '0;
  logic [31:0] dut_out_reg = '0;

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (a == DUFT_ADDR_TEST_OUT) return test_reg;
    if (a == DUFT_ADDR_DUT_OUT)  return dut_out_reg;
    return a ^ 32'h5A5A_0000;
  endfunction

  always @(negedge clk) begin
    ap_idle = !idle_block;
    if (ap_start) start_cnt++;
    else start_cnt = 0;
    ap_done = force_done || (ap_start && (start_cnt > done_lat));
    ap_ready = ap_done;
    if (ap_start) begin
      if (rd_wr) begin
        ap_return = model_read(addr);
      end else begin
        ap_return = 32'hDEAD_BEEF;
        if (addr == DUFT_ADDR_TEST_IN) test_reg = wr_data;
        if (addr == DUFT_ADDR_DUT_IN)  dut_in_reg = wr_data;
        if (addr == DUFT_ADDR_OPCODE && wr_data == DUFT_OP_RUN) dut_out_reg = dut_in_reg + 32'd8;
      end
    end
  end

  // Bench tasks
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int acc_cyc = 0;

  task automatic send(input logic rd, input logic [31:0] a, input logic [31:0] d);
    int n;
    cmd_val = 1'b1;
    cmd_rd_wr = rd;
    cmd_addr = a;
    cmd_wdata = d;
    n = 0;
    while (!cmd_rdy && n < 50) begin
      step();
      n++;
    end
    check("cmd_rdy_wait", cmd_rdy, 1);
    step();
    acc_cyc = cyc;
    cmd_val = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    int n;
    n = 0;
    while (!rsp_val && n < 500) begin
      step();
      n++;
    end
    check("rsp_wait", rsp_val, 1);
    lat = cyc - acc_cyc + 1;
  endtask

  task automatic take_rsp(output logic [31:0] rd, output logic err);
    rd = rsp_rdata;
    err = rsp_err;
    rsp_rdy = 1'b1;
    step();
    rsp_rdy = 1'b0;
  endtask

  task automatic xact(input logic rd, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rdata, output logic err, output int lat);
    send(rd, a, d);
    wait_rsp(lat);
    take_rsp(rdata, err);
  endtask

  logic [31:0] rdata;
  logic [31:0] snap;
  logic        err;
  int          lat;
  int          c0;
  int          s0;
  int          v0;
  logic [31:0] r;
  logic [31:0] a;

  initial begin
    // Reset state
    ap_rst = 1'b1;
    repeat (3) step();
    check("rst_cmd_rdy", cmd_rdy, 0);
    check("rst_rsp_val", rsp_val, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_addr", addr, 32'hFFFF_FFFF);
    check("rst_wr_data", wr_data, 0);
    check("rst_rd_wr", rd_wr, 1);
    check("rst_ap_start", ap_start, 0);
    check("rst_ap_continue", ap_continue, 0);
    check("rst_ap_ce", ap_ce, 0);
    ap_rst = 1'b0;
    #1;
    check("post_rst_cmd_rdy", cmd_rdy, 1);
    step();
    check("ce_follow_1", ap_ce, 1);

    // ap_ce follows ce_en one cycle later
    ce_en = 1'b0;
    step();
    check("ce_follow_0", ap_ce, 0);
    ce_en = 1'b1;
    step();
    check("ce_follow_1b", ap_ce, 1);

    // Write TEST_IN, inspect DUFT-side registers while the response waits
    send(1'b0, DUFT_ADDR_TEST_IN, 32'h7216);
    wait_rsp(lat);
    check("wr_test_lat", lat, 4);
    check("wr_test_addr", addr, DUFT_ADDR_TEST_IN);
    check("wr_test_rd_wr", rd_wr, 0);
    check("wr_test_wdata", wr_data, 32'h7216);
    check("wr_test_start_low", ap_start, 0);
    take_rsp(rdata, err);
    check("wr_test_rdata", rdata, 0);
    check("wr_test_err", err, 0);
    check("idle_addr", addr, 32'hFFFF_FFFF);
    check("idle_rd_wr", rd_wr, 1);
    check("idle_cmd_rdy", cmd_rdy, 1);

    // Read TEST_OUT loops back the written value
    xact(1'b1, DUFT_ADDR_TEST_OUT, 32'h0, rdata, err, lat);
    check("rd_test_rdata", rdata, 32'h0000_7216);
    check("rd_test_err", err, 0);
    check("rd_test_lat", lat, 4);

    // DUT_IN / opcode sequence / DUT_OUT
    xact(1'b0, DUFT_ADDR_DUT_IN, 32'h7216, rdata, err, lat);
    check("wr_dut_in_err", err, 0);
    xact(1'b0, DUFT_ADDR_OPCODE, DUFT_OP_INPUT, rdata, err, lat);
    xact(1'b0, DUFT_ADDR_OPCODE, DUFT_OP_RUN, rdata, err, lat);
    xact(1'b0, DUFT_ADDR_OPCODE, DUFT_OP_ENDR, rdata, err, lat);
    check("opcode_endr_rdata", rdata, 0);
    xact(1'b1, DUFT_ADDR_DUT_OUT, 32'h0, rdata, err, lat);
    check("rd_dut_out", rdata, 32'h0000_721E);
    check("rd_dut_out_err", err, 0);

    // Response back-pressure: 10 stalled cycles
    c0 = cont_cnt;
    send(1'b1, DUFT_ADDR_TEST_OUT, 32'h0);
    wait_rsp(lat);
    snap = rsp_rdata;
    check("stall_rdata_val", snap, 32'h0000_7216);
    for (int i = 0; i < 10; i++) begin
      check("stall_rsp_val", rsp_val, 1);
      check("stall_rdata", rsp_rdata, snap);
      check("stall_cmd_rdy", cmd_rdy, 0);
      step();
    end
    take_rsp(rdata, err);
    check("stall_err", err, 0);
    check("stall_cont_pulses", cont_cnt - c0, 1);

    // Stale ap_done while waiting for ap_idle is ignored
    idle_block = 1'b1;
    force_done = 1'b1;
    s0 = start_rises;
    send(1'b1, 32'h4000_1234, 32'h0);
    repeat (6) step();
    check("stale_no_rsp", rsp_val, 0);
    check("stale_no_start", start_rises - s0, 0);
    idle_block = 1'b0;
    force_done = 1'b0;
    wait_rsp(lat);
    take_rsp(rdata, err);
    check("stale_rdata", rdata, 32'h4000_1234 ^ 32'h5A5A_0000);
    check("stale_err", err, 0);

    // Timeout in S_WAIT_IDLE
    idle_block = 1'b1;
    s0 = start_rises;
    c0 = cont_cnt;
    send(1'b1, 32'h4000_0001, 32'h0);
    wait_rsp(lat);
    check("to_cycles_after_wait_idle", lat - 1, 200);
    take_rsp(rdata, err);
    check("to_err", err, 1);
    check("to_rdata", rdata, 32'hFFFF_FFFF);
    check("to_no_start", start_rises - s0, 0);
    check("to_no_continue", cont_cnt - c0, 0);
    repeat (50) step();
    idle_block = 1'b0;
    step();

    // Reset three cycles into S_WAIT_DONE
    done_lat = 1000;
    send(1'b1, 32'h4000_0002, 32'h0);
    repeat (5) step();
    check("mid_start_high", ap_start, 1);
    ap_rst = 1'b1;
    step();
    check("mid_rst_start", ap_start, 0);
    check("mid_rst_addr", addr, 32'hFFFF_FFFF);
    check("mid_rst_cmd_rdy", cmd_rdy, 0);
    check("mid_rst_ce", ap_ce, 0);
    ap_rst = 1'b0;
    done_lat = 0;
    v0 = rsp_val_cycles;
    repeat (20) step();
    check("mid_no_rsp", rsp_val_cycles - v0, 0);
    check("mid_cmd_rdy", cmd_rdy, 1);

    // 100 back-to-back random reads
    s0 = start_rises;
    for (int i = 0; i < 100; i++) begin
      r = $urandom;
      a = {8'h40, r[23:0]};
      xact(1'b1, a, 32'h0, rdata, err, lat);
      check("rnd_lat", lat, 4);
      check("rnd_rdata", rdata, a ^ 32'h5A5A_0000);
    end
    check("rnd_start_rises", start_rises - s0, 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
